// File: rtl/conv_pkg.sv
// Shared definitions for convolution-array schedulers: FSM encodings and the
// per-job window count.
package conv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_W = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } conv_state_t;

    // Number of valid 3x3 windows in an img_w x img_h image.
    function automatic int unsigned conv_total(input int unsigned img_w,
                                               input int unsigned img_h);
        return (img_w - 2) * (img_h - 2);
    endfunction

endpackage

// File: rtl/conv_result_fifo.sv
// Synchronous result FIFO with occupancy count; the head entry is presented
// from the storage registers and reads as zero while empty.
module conv_result_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_rd   = rd_en && !empty;
    // A write into a full FIFO is fine when the head leaves in the same cycle.
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/conv_array_sched.sv
// Job sequencer for the 3x3 systolic convolution array: weight load, credited
// window issue, and result collection into a backpressured output FIFO.
module conv_array_sched
    import conv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH         = 16,
    parameter int unsigned WEIGHT_WIDTH       = 8,
    parameter int unsigned ACCUM_WIDTH        = 32,
    parameter int unsigned IMG_W              = 28,
    parameter int unsigned IMG_H              = 28,
    parameter int unsigned WEIGHT_LOAD_CYCLES = 3,
    parameter int unsigned FIFO_DEPTH         = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [9*WEIGHT_WIDTH-1:0] weights_in,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    input  logic [9*DATA_WIDTH-1:0]   win_in_data,
    input  logic                      win_in_valid,
    output logic                      win_in_ready,
    output logic                      arr_enable,
    output logic [9*DATA_WIDTH-1:0]   arr_window_data_flat,
    output logic                      arr_window_valid,
    output logic [9*WEIGHT_WIDTH-1:0] arr_weights_flat,
    output logic                      arr_weights_valid,
    input  logic [ACCUM_WIDTH-1:0]    arr_conv_result,
    input  logic                      arr_result_valid,
    output logic [ACCUM_WIDTH-1:0]    out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last
);

    localparam int unsigned TOTAL  = conv_total(IMG_W, IMG_H);
    localparam int unsigned CNT_W  = $clog2(TOTAL + 1);
    localparam int unsigned OCC_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OCC1_W = OCC_W + 1;
    localparam int unsigned LD_W   = (WEIGHT_LOAD_CYCLES > 1) ? $clog2(WEIGHT_LOAD_CYCLES) : 1;

    conv_state_t       state;
    logic [LD_W-1:0]   ld_cnt;
    logic [CNT_W-1:0]  issued;
    logic [CNT_W-1:0]  popped;
    logic [OCC_W-1:0]  inflight;
    logic              stale;

    logic [OCC_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic [ACCUM_WIDTH-1:0] fifo_rd_data;

    logic              start_acc;
    logic              fire;
    logic              pop;
    logic              res_take;
    logic              res_bad;
    logic              last_pop;
    logic [OCC1_W-1:0] occupancy;

    assign start_acc = start && (state == ST_IDLE);
    assign fire      = win_in_valid && win_in_ready;
    assign pop       = out_valid && out_ready;
    assign last_pop  = pop && (popped == CNT_W'(TOTAL - 1));

    // Results still in the array pipe when reset hit are silently discarded.
    assign res_take = arr_result_valid && !stale && (inflight != '0) && (!fifo_full || pop);
    assign res_bad  = arr_result_valid && !stale && !res_take;

    // Credits include the window strobed this cycle, not yet counted in inflight.
    assign occupancy    = OCC1_W'(inflight) + OCC1_W'(arr_window_valid) + OCC1_W'(fifo_count);
    assign win_in_ready = (state == ST_STREAM) && (issued < CNT_W'(TOTAL))
                          && (occupancy < OCC1_W'(FIFO_DEPTH));

    assign arr_enable = busy;
    assign out_valid  = !fifo_empty;
    assign out_data   = fifo_rd_data;
    assign out_last   = out_valid && (popped == CNT_W'(TOTAL - 1));

    // Job FSM with registered status outputs and the latched kernel.
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= ST_IDLE;
            ld_cnt            <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            error             <= 1'b0;
            stale             <= 1'b1;
            arr_weights_valid <= 1'b0;
            arr_weights_flat  <= '0;
        end else begin
            done <= 1'b0;
            if (res_bad) begin
                error <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state             <= ST_LOAD_W;
                        ld_cnt            <= '0;
                        busy              <= 1'b1;
                        error             <= 1'b0;
                        stale             <= 1'b0;
                        arr_weights_valid <= 1'b1;
                        arr_weights_flat  <= weights_in;
                    end
                end
                ST_LOAD_W: begin
                    if (ld_cnt == LD_W'(WEIGHT_LOAD_CYCLES - 1)) begin
                        state <= ST_STREAM;
                    end else begin
                        ld_cnt <= ld_cnt + LD_W'(1);
                    end
                end
                ST_STREAM: begin
                    if (issued == CNT_W'(TOTAL)) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if ((popped == CNT_W'(TOTAL)) || last_pop) begin
                        state             <= ST_DONE;
                        busy              <= 1'b0;
                        arr_weights_valid <= 1'b0;
                        done              <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Window issue path and job counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            arr_window_valid     <= 1'b0;
            arr_window_data_flat <= '0;
            issued               <= '0;
            popped               <= '0;
            inflight             <= '0;
        end else begin
            arr_window_valid <= fire;
            if (fire) begin
                arr_window_data_flat <= win_in_data;
            end
            if (start_acc) begin
                issued   <= '0;
                popped   <= '0;
                inflight <= '0;
            end else begin
                if (fire) begin
                    issued <= issued + CNT_W'(1);
                end
                if (pop) begin
                    popped <= popped + CNT_W'(1);
                end
                case ({arr_window_valid, res_take})
                    2'b10:   inflight <= inflight + OCC_W'(1);
                    2'b01:   inflight <= inflight - OCC_W'(1);
                    default: inflight <= inflight;
                endcase
            end
        end
    end

    conv_result_fifo #(
        .WIDTH (ACCUM_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (start_acc),
        .wr_en   (res_take),
        .wr_data (arr_conv_result),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule
